// File: rtl/bch_decoder.sv
// Serial Meggitt decoder for the BCH(15,7) t=2 code, g(x) = x^8+x^7+x^6+x^4+1.
// Collects 15 bits, corrects up to 2 errors, streams 7 message bits and reports status.
module bch_decoder #(
  parameter int unsigned P_N     = 15,
  parameter int unsigned P_K     = 7,
  parameter logic [7:0]  P_GPOLY = 8'hD1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_r,
  input  logic       i_dv,
  output logic       o_ready,
  output logic       o_m,
  output logic       o_mv,
  output logic       o_done,
  output logic [1:0] o_err_cnt,
  output logic       o_uncorr
);

  typedef enum logic [1:0] {StCollect, StDecode, StDone, StFinish} state_e;

  function automatic logic [7:0] mul_x(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? P_GPOLY : 8'h00);
  endfunction

  function automatic logic [7:0] pow_x(input int unsigned n);
    logic [7:0] v;
    v = 8'h01;
    for (int unsigned i = 0; i < n; i++) v = mul_x(v);
    return v;
  endfunction

  // Syndrome of a single error in the leading (degree 14) position.
  localparam logic [7:0] ErrHead = pow_x(P_N - 1);
  localparam logic [3:0] LastBit = 4'(P_N - 1);
  localparam logic [3:0] MsgLen  = 4'(P_K);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  syn_q, syn_d;
  logic [14:0] buf_q, buf_d;
  logic [1:0]  err_q, err_d;
  logic        m_q, m_d;
  logic        mv_q, mv_d;
  logic        done_q, done_d;
  logic [1:0]  err_cnt_q, err_cnt_d;
  logic        uncorr_q, uncorr_d;

  logic        hit;
  logic [7:0]  pat;
  logic [8:0]  t;
  logic [7:0]  u;
  logic        corrected;

  // Leading bit is in error if the syndrome matches the head pattern alone or with one more error.
  always_comb begin
    hit = (syn_q == ErrHead);
    pat = 8'h01;
    for (int unsigned j = 0; j < P_N - 1; j++) begin
      if (syn_q == (ErrHead ^ pat)) hit = 1'b1;
      pat = mul_x(pat);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    syn_d     = syn_q;
    buf_d     = buf_q;
    err_d     = err_q;
    m_d       = 1'b0;
    mv_d      = 1'b0;
    done_d    = 1'b0;
    err_cnt_d = err_cnt_q;
    uncorr_d  = uncorr_q;
    t         = 9'h000;
    u         = 8'h00;
    corrected = 1'b0;
    case (state_q)
      StCollect: begin
        if (i_dv) begin
          buf_d = {buf_q[13:0], i_r};
          t     = {syn_q, 1'b0} ^ {8'h00, i_r};
          syn_d = t[8] ? (t[7:0] ^ P_GPOLY) : t[7:0];
          if (cnt_q == LastBit) begin
            cnt_d   = 4'd0;
            state_d = StDecode;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StDecode: begin
        corrected = buf_q[14] ^ hit;
        buf_d     = {buf_q[13:0], 1'b0};
        u         = syn_q ^ (hit ? ErrHead : 8'h00);
        syn_d     = mul_x(u);
        if (hit && err_q != 2'd3) err_d = err_q + 2'd1;
        if (cnt_q < MsgLen) begin
          m_d  = corrected;
          mv_d = 1'b1;
        end
        if (cnt_q == LastBit) begin
          cnt_d   = 4'd0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        done_d    = 1'b1;
        err_cnt_d = err_q;
        uncorr_d  = |syn_q;
        syn_d     = 8'h00;
        err_d     = 2'd0;
        cnt_d     = 4'd0;
        state_d   = StFinish;
      end
      // Holds o_ready low while o_done is visible.
      StFinish: state_d = StCollect;
      default:  state_d = StCollect;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StCollect;
      cnt_q     <= 4'd0;
      syn_q     <= 8'h00;
      buf_q     <= 15'h0000;
      err_q     <= 2'd0;
      m_q       <= 1'b0;
      mv_q      <= 1'b0;
      done_q    <= 1'b0;
      err_cnt_q <= 2'd0;
      uncorr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      syn_q     <= syn_d;
      buf_q     <= buf_d;
      err_q     <= err_d;
      m_q       <= m_d;
      mv_q      <= mv_d;
      done_q    <= done_d;
      err_cnt_q <= err_cnt_d;
      uncorr_q  <= uncorr_d;
    end
  end

  assign o_ready   = (state_q == StCollect);
  assign o_m       = m_q;
  assign o_mv      = mv_q;
  assign o_done    = done_q;
  assign o_err_cnt = err_cnt_q;
  assign o_uncorr  = uncorr_q;

endmodule

// File: tb/tb_bch_decoder.sv
// Directed bench for bch_decoder: hand-computed words, latency, handshake and reset cases.
module tb_bch_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r = 1'b0;
  logic       dv = 1'b0;
  logic       o_ready, o_m, o_mv, o_done, o_uncorr;
  logic [1:0] o_err_cnt;

  int errors = 0;
  int checks = 0;

  int          mv_total = 0;
  int          done_total = 0;
  logic [13:0] hist = '0;

  bch_decoder dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_r       (r),
    .i_dv      (dv),
    .o_ready   (o_ready),
    .o_m       (o_m),
    .o_mv      (o_mv),
    .o_done    (o_done),
    .o_err_cnt (o_err_cnt),
    .o_uncorr  (o_uncorr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_mv) begin
      hist     <= {hist[12:0], o_m};
      mv_total <= mv_total + 1;
    end
    if (o_done) done_total <= done_total + 1;
  end

  task automatic send_word(input logic [14:0] w, input bit stall);
    for (int i = 14; i >= 0; i--) begin
      if (stall) begin
        dv = 1'b0;
        r  = 1'b1;
        @(posedge clk); #1;
      end
      dv = 1'b1;
      r  = w[i];
      @(posedge clk); #1;
    end
    dv = 1'b0;
    r  = 1'b0;
  endtask

  task automatic decode_word(input string name, input logic [14:0] w, input logic [6:0] exp_m,
                             input logic [1:0] exp_err, input logic exp_unc, input bit stall);
    int mv0, done0, lat;
    bit seen;
    mv0   = mv_total;
    done0 = done_total;
    send_word(w, stall);
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); @(negedge clk);
      if (o_done === 1'b1) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    checks++;
    if (!seen || lat != 16) begin
      errors++;
      $display("FAIL %s latency: got %0d (seen=%0d) expected 16", name, lat, seen);
    end
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_at_done: got %b expected 0", name, o_ready);
    end
    checks++;
    if (o_err_cnt !== exp_err) begin
      errors++;
      $display("FAIL %s err_cnt: got %0d expected %0d", name, o_err_cnt, exp_err);
    end
    checks++;
    if (o_uncorr !== exp_unc) begin
      errors++;
      $display("FAIL %s uncorr: got %b expected %b", name, o_uncorr, exp_unc);
    end
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_return: got ready=%b done=%b expected ready=1 done=0", name,
               o_ready, o_done);
    end
    @(negedge clk);
    checks++;
    if (hist[6:0] !== exp_m) begin
      errors++;
      $display("FAIL %s message: got %b expected %b", name, hist[6:0], exp_m);
    end
    checks++;
    if (mv_total - mv0 != 7) begin
      errors++;
      $display("FAIL %s mv_count: got %0d expected 7", name, mv_total - mv0);
    end
    checks++;
    if (done_total - done0 != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d expected 1", name, done_total - done0);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (o_ready !== 1'b1 || o_m !== 1'b0 || o_mv !== 1'b0 || o_done !== 1'b0 ||
        o_err_cnt !== 2'd0 || o_uncorr !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs: got ready=%b m=%b mv=%b done=%b err=%0d unc=%b expected 1 0 0 0 0 0",
               name, o_ready, o_m, o_mv, o_done, o_err_cnt, o_uncorr);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_clean;
    decode_word("zero_word", 15'h0000, 7'b0000000, 2'd0, 1'b0, 1'b0);
    decode_word("clean_55e5", 15'h55E5, 7'b1010101, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_single_error;
    decode_word("err_bit14", 15'h15E5, 7'b1010101, 2'd1, 1'b0, 1'b0);
    decode_word("err_bit0_stall", 15'h55E4, 7'b1010101, 2'd1, 1'b0, 1'b1);
  endtask

  task automatic test_double_error;
    decode_word("err_bits14_0", 15'h15E4, 7'b1010101, 2'd2, 1'b0, 1'b0);
  endtask

  task automatic test_uncorrectable;
    decode_word("four_errors", 15'h00AA, 7'b0000000, 2'd0, 1'b1, 1'b0);
  endtask

  task automatic test_miscorrect;
    decode_word("miscorrect_7000", 15'h7000, 7'b1110100, 2'd2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_decode;
    int mv0, done0;
    mv0 = mv_total;
    send_word(15'h15E5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle("mid_reset");
    checks++;
    if (mv_total - mv0 != 3) begin
      errors++;
      $display("FAIL mid_reset mv_before: got %0d expected 3", mv_total - mv0);
    end
    mv0   = mv_total;
    done0 = done_total;
    repeat (20) @(negedge clk);
    checks++;
    if (mv_total != mv0 || done_total != done0) begin
      errors++;
      $display("FAIL mid_reset quiet: got mv=%0d done=%0d expected 0 0", mv_total - mv0,
               done_total - done0);
    end
    check_idle("mid_reset_quiet");
    decode_word("after_reset", 15'h15E4, 7'b1010101, 2'd2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [29:0] stream;
    int idx, mv0, done0;
    logic rdy;
    stream = {15'h55E5, 15'h7000};
    idx    = 0;
    mv0    = mv_total;
    done0  = done_total;
    dv     = 1'b1;
    for (int c = 0; c < 200 && idx < 30; c++) begin
      rdy = o_ready;
      r   = rdy ? stream[29 - idx] : 1'b1;
      @(posedge clk); #1;
      if (rdy) idx++;
    end
    for (int c = 0; c < 60 && (done_total - done0) < 2; c++) @(negedge clk);
    dv = 1'b0;
    r  = 1'b0;
    @(negedge clk);
    checks++;
    if (done_total - done0 != 2) begin
      errors++;
      $display("FAIL b2b done_count: got %0d expected 2", done_total - done0);
    end
    checks++;
    if (mv_total - mv0 != 14) begin
      errors++;
      $display("FAIL b2b mv_count: got %0d expected 14", mv_total - mv0);
    end
    checks++;
    if (hist !== {7'b1010101, 7'b1110100}) begin
      errors++;
      $display("FAIL b2b messages: got %b expected %b", hist, {7'b1010101, 7'b1110100});
    end
    checks++;
    if (o_err_cnt !== 2'd2 || o_uncorr !== 1'b0) begin
      errors++;
      $display("FAIL b2b status: got err=%0d unc=%b expected err=2 unc=0", o_err_cnt, o_uncorr);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_double_error();
    test_uncorrectable();
    test_miscorrect();
    test_reset_mid_decode();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
